// File: rtl/bla_sub_pipe_if.sv
// bla_sub_pipe_if: operand/result handshake bundle for the pipelined subtractor.
// master = producer/consumer side (testbench or datapath), slave = the subtractor.
interface bla_sub_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             b_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, x, y, b_in, out_ready,
    input  in_ready, out_valid, d, b_out, ovf, zero
  );

  modport slave (
    input  in_valid, x, y, b_in, out_ready,
    output in_ready, out_valid, d, b_out, ovf, zero
  );
endinterface

// File: rtl/bla_sub_pipe.sv
// bla_sub_pipe: two-stage unsigned subtractor d = x - y - b_in with
// borrow-lookahead inside each half. S1 resolves the low half, S2 the high half.
// Optional result flags (ovf, zero) are compiled in with BLA_SUB_FLAGS_EN;
// without it both flags are constant 0.
module bla_sub_pipe #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  bla_sub_pipe_if.slave bus
);
  localparam int H = WIDTH / 2;

  // Lookahead subtract of one half: returns {borrow_out, difference}.
  // Each borrow is a flattened sum of generate terms gated by propagates.
  function automatic logic [H:0] bla_half(input logic [H-1:0] xh,
                                          input logic [H-1:0] yh,
                                          input logic         bin);
    logic [H-1:0] g;
    logic [H-1:0] p;
    logic [H:0]   bor;
    logic         term;
    g = ~xh & yh;
    p = ~(xh ^ yh);
    for (int i = 0; i <= H; i++) begin
      term = bin;
      for (int k = 0; k < i; k++) term = term & p[k];
      bor[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        bor[i] = bor[i] | term;
      end
    end
    return {bor[H], xh ^ yh ^ bor[H-1:0]};
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [H-1:0]     s1_dlo_q,   s1_dlo_d;
  logic             s1_bm_q,    s1_bm_d;
  logic [H-1:0]     s1_xhi_q,   s1_xhi_d;
  logic [H-1:0]     s1_yhi_q,   s1_yhi_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] diff_q,     diff_d;
  logic             bout_q,     bout_d;

  logic             s2_free, s1_free, accept, advance;
  logic [H:0]       lo_res, hi_res;
  logic [WIDTH-1:0] d_full;

  // Handshake: a stage is free if empty or its contents leave this cycle.
  always_comb begin
    s2_free      = !s2_valid_q || bus.out_ready;
    s1_free      = !s1_valid_q || s2_free;
    bus.in_ready = s1_free && !reset;
    accept       = bus.in_valid && bus.in_ready;
    advance      = s1_valid_q && s2_free;
  end

  // Stage datapath: low half from live operands, high half from S1 contents.
  always_comb begin
    lo_res = bla_half(bus.x[H-1:0], bus.y[H-1:0], bus.b_in);
    hi_res = bla_half(s1_xhi_q, s1_yhi_q, s1_bm_q);
    d_full = {hi_res[H-1:0], s1_dlo_q};
  end

  // S1 next state: load on accept, drain on advance, else hold.
  always_comb begin
    s1_dlo_d = s1_dlo_q;
    s1_bm_d  = s1_bm_q;
    s1_xhi_d = s1_xhi_q;
    s1_yhi_d = s1_yhi_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_dlo_d   = lo_res[H-1:0];
      s1_bm_d    = lo_res[H];
      s1_xhi_d   = bus.x[WIDTH-1:H];
      s1_yhi_d   = bus.y[WIDTH-1:H];
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // S2 next state: capture full result on advance; empties when consumed.
  always_comb begin
    diff_d = diff_q;
    bout_d = bout_q;
    if (advance) begin
      s2_valid_d = 1'b1;
      diff_d     = d_full;
      bout_d     = hi_res[H];
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_dlo_q   <= {H{1'b0}};
      s1_bm_q    <= 1'b0;
      s1_xhi_q   <= {H{1'b0}};
      s1_yhi_q   <= {H{1'b0}};
      s2_valid_q <= 1'b0;
      diff_q     <= {WIDTH{1'b0}};
      bout_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_dlo_q   <= s1_dlo_d;
      s1_bm_q    <= s1_bm_d;
      s1_xhi_q   <= s1_xhi_d;
      s1_yhi_q   <= s1_yhi_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      bout_q     <= bout_d;
    end
  end

`ifdef BLA_SUB_FLAGS_EN
  logic ovf_q,  ovf_d;
  logic zero_q, zero_d;

  // Flag next state: signed overflow and zero result, captured with S2.
  always_comb begin
    if (advance) begin
      ovf_d  = (s1_xhi_q[H-1] != s1_yhi_q[H-1]) && (d_full[WIDTH-1] != s1_xhi_q[H-1]);
      zero_d = (d_full == {WIDTH{1'b0}});
    end else begin
      ovf_d  = ovf_q;
      zero_d = zero_q;
    end
  end

  // Flag registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
`else
  assign bus.ovf  = 1'b0;
  assign bus.zero = 1'b0;
`endif

  assign bus.out_valid = s2_valid_q;
  assign bus.d         = diff_q;
  assign bus.b_out     = bout_q;
endmodule

// File: tb/tb_bla_sub_pipe.sv
// tb_bla_sub_pipe: scoreboard bench for bla_sub_pipe. Expected results come
// from integer arithmetic on the operands; a monitor pops and compares them.
module tb_bla_sub_pipe;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         b_out;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   acc_cnt;
  bit   sending;
  exp_t exp_q[$];

  bla_sub_pipe_if #(.WIDTH(W)) bus ();

  bla_sub_pipe #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer subtraction, unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv);
    exp_t e;
    int   ud;
    int   sd;
    ud      = int'(xv) - int'(yv) - int'(bv);
    sd      = int'($signed(xv)) - int'($signed(yv)) - int'(bv);
    e.d     = ud[W-1:0];
    e.b_out = (ud < 0);
`ifdef BLA_SUB_FLAGS_EN
    e.ovf   = (sd < -128) || (sd > 127);
    e.zero  = (ud[W-1:0] == 8'h00);
`else
    e.ovf   = 1'b0;
    e.zero  = (sd == 12345);
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Offer one operand set; block until accepted or time out.
  task automatic send_op(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv,
                         output int waited);
    bit done;
    done         = 1'b0;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.x        = xv;
    bus.y        = yv;
    bus.b_in     = bv;
    while (!done && waited < 50) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(model(xv, yv, bv));
        acc_cnt++;
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.x        = 8'($urandom);
    bus.y        = 8'($urandom);
    chk("accept_timeout", {31'd0, done}, 32'd1);
  endtask

  // Single op into an empty pipe: check 2-edge latency and spec constants.
  task automatic directed(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv,
                          input logic [W-1:0] dv, input logic bov);
    int w;
    send_op(xv, yv, bv, w);
    @(negedge clk);
    chk("latency_one_edge", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("latency_two_edges", {31'd0, bus.out_valid}, 32'd1);
    chk("directed_d", {24'd0, bus.d}, {24'd0, dv});
    chk("directed_b_out", {31'd0, bus.b_out}, {31'd0, bov});
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  // Monitor: every handshaken result is compared with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {21'd0, bus.d, bus.b_out, bus.ovf, bus.zero},
              {21'd0, e.d, e.b_out, e.ovf, e.zero});
        end
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int           w;
    logic [W-1:0] held_d;
    logic         held_b;
    n_checks      = 0;
    n_fail        = 0;
    acc_cnt       = 0;
    sending       = 1'b0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x         = 8'h00;
    bus.y         = 8'h00;
    bus.b_in      = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_d", {24'd0, bus.d}, 32'd0);
    chk("reset_flags", {30'd0, bus.b_out, bus.ovf, bus.zero}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed cases from the test plan.
    directed(8'h50, 8'h20, 1'b0, 8'h30, 1'b0);
    directed(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    directed(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
    directed(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    directed(8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0);
    directed(8'h0F, 8'h10, 1'b0, 8'hFF, 1'b1);

    // Back-to-back random: 16 ops, each accepted without a wait.
    for (int i = 0; i < 16; i++) begin
      send_op(8'($urandom), 8'($urandom), 1'($urandom), w);
      chk("throughput_no_wait", w, 32'd0);
    end
    drain();

    // Backpressure: 4 ops with the consumer stalled.
    acc_cnt       = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_op(8'($urandom), 8'($urandom), 1'($urandom), w);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_accepts", acc_cnt, 32'd2);
        chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        held_d = bus.d;
        held_b = bus.b_out;
        repeat (2) begin
          @(negedge clk);
          chk("bp_d_stable", {23'd0, bus.d, bus.b_out}, {23'd0, held_d, held_b});
          chk("bp_still_blocked", {31'd0, bus.in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_all_accepted", acc_cnt, 32'd4);

    // Random stream against random consumer stalls.
    sending = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) send_op(8'($urandom), 8'($urandom), 1'($urandom), w);
        sending = 1'b0;
      end
      begin
        while (sending) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    send_op(8'h44, 8'h11, 1'b0, w);
    send_op(8'h99, 8'h22, 1'b1, w);
    chk("full_before_reset", {31'd0, bus.out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_reset_d", {24'd0, bus.d}, 32'd0);
    chk("async_reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    directed(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bla_sub_pipe.md
# bla_sub_pipe

Two-stage pipelined unsigned subtractor with borrow-lookahead. It computes `d = x - y - b_in`, splitting the operand into a low half and a high half with one register stage per half. It has valid/ready handshakes on both sides and sits next to the carry-lookahead adder in the arithmetic datapath, covering subtraction and compare at full throughput.

## Interface
- `WIDTH`, default 8: operand width. Must be even and ≥ 4. Low half is `[WIDTH/2-1:0]`, high half is `[WIDTH-1:WIDTH/2]`.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high. Clears all pipeline state.
- `in_valid` in 1: operands present.
- `in_ready` out 1: block accepts operands this cycle.
- `x` in WIDTH: minuend.
- `y` in WIDTH: subtrahend.
- `b_in` in 1: borrow-in.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts the result.
- `d` out WIDTH: difference, modulo 2^WIDTH.
- `b_out` out 1: borrow-out. It is 1 iff `x < y + b_in` (unsigned).
- `ovf` out 1: signed overflow flag (see Configuration).
- `zero` out 1: `d == 0` flag (see Configuration).

## Operation
- Borrow generate per bit: `g_i = ~x_i & y_i`. Borrow propagate per bit: `p_i = ~(x_i ^ y_i)`. Borrows inside each half come from flattened lookahead equations, not a ripple chain. Difference bit: `d_i = x_i ^ y_i ^ bor_i`.
- Stage 1 (S1), on accept:
  - computes the low-half difference and borrow `bm` out of the low half;
  - registers the low difference, `bm`, and the raw high halves of `x` and `y`;
  - sets `s1_valid`.
- Stage 2 (S2), on advance:
  - computes the high-half difference with borrow-in `bm`;
  - registers the full `d`, `b_out`, and flags;
  - sets `s2_valid`.
- `out_valid` = `s2_valid`.
- Flow control:
  - `s2_free = !s2_valid || out_ready`
  - `s1_free = !s1_valid || s2_free`
  - `in_ready = s1_free`, forced 0 while `reset` is high.
- S1 → S2 transfer happens when `s1_valid && s2_free`. Input accept happens when `in_valid && in_ready`. Both can occur in the same cycle.
- Output hold: while `out_valid && !out_ready`, `d`, `b_out`, `ovf` and `zero` hold stable, and S1 holds its contents.
- Results leave in acceptance order. No operand is dropped or duplicated.
- Inputs are don't-care when `in_valid` = 0. Register enables gate on accept/advance only.

## Timing
- Reset values: `out_valid` = 0, `d` = 0, `b_out` = 0, `ovf` = 0, `zero` = 0. Internally `s1_valid` = 0 and `s2_valid` = 0.
- Latency: operands accepted at edge N give `out_valid` = 1 after edge N+1, i.e. two edges, provided `out_ready` is held high.
- Throughput: one operation per cycle with `out_ready` = 1.
- Backpressure: with `out_ready` = 0, at most 2 operations are buffered (S1 + S2). `in_ready` falls in the cycle when both stages are full.
- Simultaneous consume and accept when full: `out_ready` = 1 with S1 and S2 full lets S1 advance, and `in_ready` = 1 in the same cycle.
- `in_ready` depends combinationally on `out_ready`. `out_valid` and `d` come straight from registers.
- Reset mid-operation: all in-flight operations are discarded. Outputs return to reset values asynchronously. The first post-reset accept behaves as from idle.

## Configuration
- Macro `BLA_SUB_FLAGS_EN` compiles in the result flags. It adds one S2 register each for `ovf` and `zero`:
  - `ovf = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1])`
  - `zero = (d == 0)`
- Without the macro, `ovf` and `zero` are tied to 0 and no flag logic exists. Datapath, latency and handshake are identical either way.

## Test plan
- Basic subtract: `x` = 0x50, `y` = 0x20, `b_in` = 0, `out_ready` = 1 → two edges later `d` = 0x30, `b_out` = 0, `zero` = 0.
- Cross-half borrow: `x` = 0x00, `y` = 0x01, `b_in` = 0 → `d` = 0xFF, `b_out` = 1, `ovf` = 0. Also `x` = 0x10, `y` = 0x10, `b_in` = 1 → `d` = 0xFF, `b_out` = 1.
- Flags (macro defined): `x` = 0x80, `y` = 0x01 → `d` = 0x7F, `b_out` = 0, `ovf` = 1. `x` = 0x3C, `y` = 0x3C → `d` = 0x00, `zero` = 1. With the macro undefined, both flags stay 0.
- Back-to-back: 16 consecutive random operand pairs, one per cycle, `out_ready` = 1 → 16 results in order, one per cycle, each matching the reference model `{b_out, d} = x - y - b_in` over 9 bits.
- Backpressure:
  - stream 4 ops with `out_ready` held 0 for 3 cycles → `in_ready` drops after 2 accepts, and `d` stays stable while stalled;
  - on release, all 4 results appear in order with none lost.
- Reset: assert `reset` for 1 cycle with both stages full → `out_valid` = 0 and `d` = 0 immediately; the next op, `x` = 0x05, `y` = 0x03, returns `d` = 0x02 with 2-edge latency.
